// File: rtl/fft_src_pkg.sv
// fft_src_pkg -- shared types and helpers for the fft_frame_source player.
//   state_t     : player FSM states (IDLE, PLAY, GAP, DONE)
//   N_DEF       : default frame length; DEPTH_DEF : default memory depth
//   ADDR_W      : address width for the default memory depth
//   IDX_W       : bin index width for the default frame length
//   BR_W        : widest index the bit-reverse helper handles (N = 8192)
//   bit_reverse : reverses the low w bits of v
package fft_src_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned N_DEF     = 64;
   localparam int unsigned DEPTH_DEF = 8192;
   localparam int unsigned ADDR_W    = $clog2(DEPTH_DEF);
   localparam int unsigned IDX_W     = $clog2(N_DEF);
   localparam int unsigned BR_W      = 13;

   // Reverse all BR_W bits, then shift the w interesting bits back down.
   function automatic logic [BR_W-1:0] bit_reverse(input logic [BR_W-1:0] v,
                                                   input int unsigned w);
      logic [BR_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < BR_W; i++) begin
         r[BR_W-1-i] = v[i];
      end
      return r >> (BR_W - w);
   endfunction

endpackage

// File: rtl/fft_src_ram.sv
// fft_src_ram -- simple dual-port sample RAM, DEPTH x DW, registered read.
//   clk     : clock
//   wr_en   : write strobe        wr_addr/wr_data : write port
//   rd_en   : read strobe         rd_addr         : read address
//   rd_data : read data, one cycle after rd_en; a same-cycle write to the
//             read address returns the old contents.
module fft_src_ram #(
   parameter int unsigned DEPTH = 8192,
   parameter int unsigned DW    = 32
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DW-1:0]            rd_data
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   always_comb rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_source.sv
// fft_frame_source -- plays frames of N complex samples from on-chip memory
// into the FFT core and tags the FFT output stream with bin/frame counts.
//   clk, rst                 : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data    : sample memory load port ({re, im})
//   start, stop              : burst start (IDLE only) / stop at frame boundary
//   num_frames, gap_cycles,
//   continuous               : burst configuration, captured on start
//   src_valid/src_re/src_im  : stream to the FFT input
//   busy, done               : not-IDLE flag, end-of-burst pulse
//   fft_valid                : FFT output strobe
//   bin_index, out_frame     : sink-side sample index and completed frames
// Optional: define FFT_SRC_BITREV_EN to present bin_index bit-reversed.
module fft_frame_source
   import fft_src_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned GAP_W = 8,
   parameter int unsigned FRM_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [2*WIDTH-1:0]       wr_data,
   input  logic                     start,
   input  logic                     stop,
   input  logic [FRM_W-1:0]         num_frames,
   input  logic [GAP_W-1:0]         gap_cycles,
   input  logic                     continuous,
   output logic                     src_valid,
   output logic [WIDTH-1:0]         src_re,
   output logic [WIDTH-1:0]         src_im,
   output logic                     busy,
   output logic                     done,
   input  logic                     fft_valid,
   output logic [$clog2(N)-1:0]     bin_index,
   output logic [FRM_W-1:0]         out_frame
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned IW = $clog2(N);

   state_t           state_q, state_d;
   logic [IW-1:0]    k_q, k_d;
   logic [AW-1:0]    base_q, base_d;
   logic [FRM_W-1:0] frm_q, frm_d, num_q, num_d, frm_inc;
   logic [GAP_W-1:0] gap_q, gap_d, gcfg_q, gcfg_d;
   logic             cont_q, cont_d, stop_pend_q, stop_pend_d;
   logic             rd_vld_q, rd_vld_d;
   logic             src_valid_q, src_valid_d;
   logic [WIDTH-1:0] src_re_q, src_re_d, src_im_q, src_im_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [IW-1:0]    bin_q, bin_d;
   logic [FRM_W-1:0] out_frame_q, out_frame_d;

   logic             rd_en, advance, end_burst;
   logic [AW-1:0]    rd_addr;
   logic [2*WIDTH-1:0] rd_data;

   fft_src_ram #(
      .DEPTH (DEPTH),
      .DW    (2*WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      base_d      = base_q;
      frm_d       = frm_q;
      num_d       = num_q;
      gap_d       = gap_q;
      gcfg_d      = gcfg_q;
      cont_d      = cont_q;
      stop_pend_d = stop_pend_q;
      rd_en       = 1'b0;
      advance     = 1'b0;
      rd_addr     = base_q + AW'(k_q);
      frm_inc     = frm_q + 1'b1;
      end_burst   = (~cont_q & (frm_inc == num_q)) | stop_pend_q | stop;

      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            if (start) begin
               state_d = PLAY;
               k_d     = '0;
               base_d  = '0;
               frm_d   = '0;
               gap_d   = '0;
               num_d   = (num_frames == '0) ? FRM_W'(1) : num_frames;
               gcfg_d  = gap_cycles;
               cont_d  = continuous;
            end
         end
         PLAY: begin
            rd_en       = 1'b1;
            stop_pend_d = stop_pend_q | stop;
            // N is a power of two, so k wraps to 0 by itself after N-1.
            k_d         = k_q + 1'b1;
            if (k_q == IW'(N-1)) begin
               if (gcfg_q != '0) begin
                  state_d = GAP;
                  gap_d   = '0;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         GAP: begin
            if (stop | stop_pend_q) begin
               state_d = DONE;
            end else if (gap_q == gcfg_q - 1'b1) begin
               advance = 1'b1;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         DONE: begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      // Shared next-frame decision for the end of PLAY and the end of GAP.
      if (advance) begin
         if (end_burst) begin
            state_d = DONE;
         end else begin
            state_d = PLAY;
            frm_d   = frm_inc;
            base_d  = base_q + AW'(N);
         end
      end

      // Two-stage output pipeline: RAM read register, then output register.
      rd_vld_d    = rd_en;
      src_valid_d = rd_vld_q;
      src_re_d    = rd_vld_q ? rd_data[2*WIDTH-1:WIDTH] : src_re_q;
      src_im_d    = rd_vld_q ? rd_data[WIDTH-1:0]       : src_im_q;
      done_d      = (state_d == DONE);
      busy_d      = (state_d != IDLE);

      bin_d       = bin_q;
      out_frame_d = out_frame_q;
      if (fft_valid) begin
         bin_d = bin_q + 1'b1;
         if (bin_q == IW'(N-1)) out_frame_d = out_frame_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         base_q      <= '0;
         frm_q       <= '0;
         num_q       <= '0;
         gap_q       <= '0;
         gcfg_q      <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         rd_vld_q    <= 1'b0;
         src_valid_q <= 1'b0;
         src_re_q    <= '0;
         src_im_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         bin_q       <= '0;
         out_frame_q <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         base_q      <= base_d;
         frm_q       <= frm_d;
         num_q       <= num_d;
         gap_q       <= gap_d;
         gcfg_q      <= gcfg_d;
         cont_q      <= cont_d;
         stop_pend_q <= stop_pend_d;
         rd_vld_q    <= rd_vld_d;
         src_valid_q <= src_valid_d;
         src_re_q    <= src_re_d;
         src_im_q    <= src_im_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         bin_q       <= bin_d;
         out_frame_q <= out_frame_d;
      end
   end

   always_comb begin
      src_valid = src_valid_q;
      src_re    = src_re_q;
      src_im    = src_im_q;
      busy      = busy_q;
      done      = done_q;
      out_frame = out_frame_q;
`ifdef FFT_SRC_BITREV_EN
      bin_index = IW'(bit_reverse(BR_W'(bin_q), IW));
`else
      bin_index = bin_q;
`endif
   end

endmodule

// File: tb/tb_fft_frame_source.sv
module tb_fft_frame_source;
   import fft_src_pkg::*;

   localparam int N   = 64;
   localparam int WIN = 1024;
`ifdef FFT_SRC_BITREV_EN
   localparam int BIN1_LIT   = 32;
   localparam int BIN130_LIT = 16;
`else
   localparam int BIN1_LIT   = 1;
   localparam int BIN130_LIT = 2;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, wr_en, start, stop, continuous, fft_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [7:0]        num_frames, gap_cycles;

   logic             v1, busy1, done1, v2, busy2, done2;
   logic [15:0]      re1, im1, re2, im2;
   logic [IDX_W-1:0] bin1, bin2;
   logic [7:0]       of1, of2;

   fft_frame_source #(.N(N), .WIDTH(16), .DEPTH(DEPTH_DEF), .GAP_W(8), .FRM_W(8)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .stop(stop), .num_frames(num_frames), .gap_cycles(gap_cycles),
      .continuous(continuous), .src_valid(v1), .src_re(re1), .src_im(im1),
      .busy(busy1), .done(done1), .fft_valid(fft_valid), .bin_index(bin1),
      .out_frame(of1));

   // Small-memory instance: frame bases wrap after two frames.
   fft_frame_source #(.N(N), .WIDTH(16), .DEPTH(128), .GAP_W(8), .FRM_W(8)) u2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[6:0]), .wr_data(wr_data),
      .start(start), .stop(stop), .num_frames(num_frames), .gap_cycles(gap_cycles),
      .continuous(continuous), .src_valid(v2), .src_re(re2), .src_im(im2),
      .busy(busy2), .done(done2), .fft_valid(fft_valid), .bin_index(bin2),
      .out_frame(of2));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference memory images and per-cycle expectations for the current burst.
   logic [31:0] m1 [256];
   logic [31:0] m2 [128];
   bit          ev  [WIN];
   bit          eb  [WIN];
   bit          edn [WIN];
   logic [31:0] ed1 [WIN];
   logic [31:0] ed2 [WIN];
   logic [31:0] last1 = '0, last2 = '0;
   int  t0 = 0, t_end = 0;
   bit  chk_en = 1'b0;
   int  errs = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int exp_bin(input int v);
      int r = v;
`ifdef FFT_SRC_BITREV_EN
      r = 0;
      for (int b = 0; b < 6; b++) r = (r << 1) | ((v >> b) & 1);
`endif
      return r;
   endfunction

   // Build the expected timeline from the burst rules: frame f reads start
   // at relative cycle 1 + f*(N+g); data appears two cycles after its read.
   task automatic plan(input int nf, input int g, input bit cont, input int s,
                       output int tend);
      int flim, f, r0, e, d;
      logic [31:0] l1, l2;
      for (int i = 0; i < WIN; i++) begin
         ev[i] = 0; eb[i] = 0; edn[i] = 0; ed1[i] = '0; ed2[i] = '0;
      end
      flim = cont ? 1000 : ((nf == 0) ? 1 : nf);
      f = 0; e = 0;
      while (f < flim && f < 8) begin
         r0 = 1 + f * (N + g);
         if (f > 0 && s >= 1 && s < r0) break;
         for (int k = 0; k < N; k++) begin
            ev[r0 + 2 + k]  = 1;
            ed1[r0 + 2 + k] = m1[(f * N + k) % 256];
            ed2[r0 + 2 + k] = m2[(f * N + k) % 128];
         end
         e = r0 + N - 1;
         f++;
      end
      if (g == 0)                    d = e + 1;
      else if (s >= 1 && s <= e + g) d = ((s > e + 1) ? s : e + 1) + 1;
      else                           d = e + g + 1;
      for (int i = 1; i <= d; i++) eb[i] = 1;
      edn[d] = 1;
      tend = d + 4;
      l1 = last1; l2 = last2;
      for (int i = 0; i < WIN; i++) begin
         if (ev[i]) begin l1 = ed1[i]; l2 = ed2[i]; end
         else begin ed1[i] = l1; ed2[i] = l2; end
      end
      last1 = l1; last2 = l2;
   endtask

   always @(negedge clk) begin
      if (chk_en && cyc >= t0 && cyc <= t_end) begin
         chk("src_valid1", v1, ev[cyc - t0]);
         chk("src_valid2", v2, ev[cyc - t0]);
         chk("busy1", busy1, eb[cyc - t0]);
         chk("busy2", busy2, eb[cyc - t0]);
         chk("done1", done1, edn[cyc - t0]);
         chk("done2", done2, edn[cyc - t0]);
         chk("data1", {re1, im1}, ed1[cyc - t0]);
         chk("data2", {re2, im2}, ed2[cyc - t0]);
      end
   end

   task automatic run_burst(input int nf, input int g, input bit cont, input int s_rel,
                            input int ign_rel, input int lit_rel, input logic [15:0] lit1,
                            input logic [15:0] lit2, input int done_rel);
      int tend;
      @(posedge clk); #1;
      num_frames = 8'(nf); gap_cycles = 8'(g); continuous = cont;
      start = 1'b1; stop = (s_rel == 0);
      t0 = cyc;
      plan(nf, g, cont, s_rel, tend);
      t_end = t0 + tend;
      chk_en = 1'b1;
      for (int r = 1; r <= tend; r++) begin
         @(posedge clk); #1;
         start = (r == ign_rel);
         stop  = (r == s_rel);
         if (r == 1) begin
            num_frames = 8'(nf + 7); gap_cycles = 8'(g + 3); continuous = ~cont;
         end
         if (r == lit_rel) begin
            chk("lit_valid", v1, 1);
            chk("lit_re1", re1, lit1);
            chk("lit_re2", re2, lit2);
         end
         if (r == done_rel) begin
            chk("lit_done1", done1, 1);
            chk("lit_done2", done2, 1);
         end
         if (r == done_rel + 1) chk("lit_busy_low", busy1, 0);
      end
      @(negedge clk); #1;
      chk_en = 1'b0;
      start = 1'b0; stop = 1'b0;
   endtask

   initial begin
      rst = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; stop = 0;
      num_frames = 0; gap_cycles = 0; continuous = 0; fft_valid = 0;
      repeat (3) @(negedge clk);
      chk("rst_valid", v1, 0); chk("rst_busy", busy1, 0); chk("rst_done", done1, 0);
      chk("rst_data", {re1, im1}, 0); chk("rst_bin", bin1, 0); chk("rst_frame", of1, 0);
      chk("rst_valid2", v2, 0); chk("rst_data2", {re2, im2}, 0);
      rst = 1'b0;

      // Load re = k, im = -k at addresses 0..255.
      for (int k = 0; k < 256; k++) begin
         @(posedge clk); #1;
         wr_en = 1'b1; wr_addr = ADDR_W'(k);
         wr_data = {16'(k), 16'(0 - k)};
         m1[k] = wr_data; m2[k % 128] = wr_data;
      end
      @(posedge clk); #1 wr_en = 1'b0;
      repeat (3) @(posedge clk);

      // Single frame, start and stop together (stop ignored).
      run_burst(1, 0, 0, 0, -1, 13, 16'd10, 16'd138, 65);
      // Three frames with 5-cycle gaps, plus a start while busy.
      run_burst(3, 5, 0, -1, 30, 72, 16'd64, 16'd192, 208);
      // Continuous, stop in the middle of frame 2.
      run_burst(0, 0, 1, 149, -1, 72, 16'd69, 16'd197, 193);
      // Continuous with gap: stop pending from frame 0, then stop in a gap.
      run_burst(0, 4, 1, 10, -1, 3, 16'd0, 16'd128, 66);
      run_burst(0, 6, 1, 67, -1, 3, 16'd0, 16'd128, 68);
      // num_frames = 0 plays one frame, followed by its gap.
      run_burst(0, 2, 0, -1, -1, 3, 16'd0, 16'd128, 67);

      // Sink counter over 130 output samples.
      for (int i = 0; i < 130; i++) begin
         @(posedge clk); #1 fft_valid = 1'b1;
         #1;
         chk("bin1", bin1, exp_bin(i % 64));
         chk("bin2", bin2, exp_bin(i % 64));
         chk("out_frame1", of1, (i / 64) % 256);
         if (i == 1) chk("lit_bin1", bin1, BIN1_LIT);
      end
      @(posedge clk); #1 fft_valid = 1'b0;
      #1;
      chk("lit_out_frame", of1, 2);
      chk("lit_out_frame2", of2, 2);
      chk("lit_bin130", bin1, BIN130_LIT);

      // Reset in the middle of a burst.
      @(posedge clk); #1;
      num_frames = 8'd3; gap_cycles = 8'd0; continuous = 1'b0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_valid", v1, 0); chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_done", done1, 0); chk("mid_rst_data", {re1, im1}, 0);
      chk("mid_rst_frame", of1, 0); chk("mid_rst_valid2", v2, 0);
      chk("mid_rst_data2", {re2, im2}, 0);
      last1 = '0; last2 = '0;
      @(posedge clk); #3 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("post_rst_done", done1, 0);
         chk("post_rst_busy", busy1, 0);
      end
      // Replays from frame 0 after reset.
      run_burst(1, 0, 0, -1, -1, 13, 16'd10, 16'd138, 65);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/fft_frame_source.md
Name: fft_frame_source

Overview:
Synthesizable, parametrised frame player that feeds the FFT core from on-chip sample memory.
- Replaces the bench-only file-load-and-drive loop.
- Memory is loaded through a write port. Frames of N complex samples are then streamed with a contiguous valid strobe.
- Supports multi-frame bursts, programmable inter-frame gaps and continuous (looping) mode.
- A sink-side bin/frame counter tags FFT output samples for capture and debug.

Parameters:
- N, 64, FFT frame length in samples; power of two, 8..8192.
- WIDTH, 16, bits per real/imag component.
- DEPTH, 8192, sample memory depth in words; power of two, ≥ N.
- GAP_W, 8, width of the gap_cycles input.
- FRM_W, 8, width of the num_frames input and frame counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  memory write strobe
- wr_addr  in  log2(DEPTH)  write address
- wr_data  in  2*WIDTH  packed sample: [2W-1:W]=re, [W-1:0]=im
- start  in  1  one-cycle pulse; accepted only in IDLE
- stop  in  1  one-cycle pulse; aborts at the next frame boundary
- num_frames  in  FRM_W  frames per burst; 0 treated as 1
- gap_cycles  in  GAP_W  idle cycles between frames
- continuous  in  1  1 = loop frames until stop
- src_valid  out  1  drives FFT enable_in
- src_re  out  WIDTH  drives FFT in_re
- src_im  out  WIDTH  drives FFT in_im
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a burst completes or stop takes effect
- fft_valid  in  1  FFT enable_out
- bin_index  out  log2(N)  index of the current FFT output sample
- out_frame  out  FRM_W  count of completed output frames (wraps)

Behaviour:
- Reset: all outputs 0; state IDLE; sample counter, frame counter, gap counter and read address = 0. Memory contents are not cleared.
- Memory: single write port, synchronous read with 1-cycle latency. A write to an address being read in the same cycle returns old data.
- Configuration: num_frames, gap_cycles and continuous are sampled on the accepted start and held for the whole burst.
- FSM:
  - IDLE -> PLAY on start.
  - PLAY: issue read address base+k for k = 0..N-1, one per cycle. After k = N-1, go to GAP if gap_cycles > 0, else directly to the next frame.
  - Next-frame decision: frame counter+1 == num_frames and continuous = 0, or stop pending -> DONE; otherwise PLAY for the next frame.
  - GAP: count gap_cycles cycles with no reads issued, then make the next-frame decision.
  - DONE: asserts done for one cycle, then -> IDLE.
- Frame base: frame f reads from (f*N) mod DEPTH. Wraps to 0 when f*N reaches DEPTH.
- Output timing:
  - src_valid/src_re/src_im are registered and appear 2 cycles after the corresponding read address is issued.
  - The first src_valid occurs in the 3rd cycle after the start pulse.
  - src_valid is high for exactly N consecutive cycles per frame and low for exactly gap_cycles cycles between frames.
  - src_re/src_im hold their last value while src_valid = 0.
- stop: latched as pending. The current frame always completes in full (no truncated frames). If asserted during GAP, go to DONE immediately. Ignored in IDLE. Simultaneous start and stop in IDLE: start accepted, stop ignored.
- start while busy: ignored.
- Sink counter: on each fft_valid cycle, bin_index increments modulo N. When bin_index = N-1 with fft_valid high, bin_index wraps to 0 and out_frame increments, wrapping at 2^FRM_W. bin_index shows the index of the sample present in the same cycle, i.e. it is combinationally valid with fft_valid.
- Reset mid-burst: immediate return to IDLE with outputs zeroed; no done pulse.

Optional Feature:
- FFT_SRC_BITREV_EN
  - Defined: bin_index is presented bit-reversed (log2(N) bits), so natural-order bin numbers are reported for the bit-reversed output of the 2^2 SDF core.
  - Undefined: bin_index is the plain sequential count.
- Counter behaviour and out_frame are identical in both cases.

Decomposition:
- Package fft_src_pkg:
  - state enum (IDLE, PLAY, GAP, DONE)
  - localparams ADDR_W = log2(DEPTH), IDX_W = log2(N)
  - a bit-reverse function
- One sub-module, fft_src_ram: simple dual-port RAM, DEPTH × 2*WIDTH, registered read.
- FSM, counters and sink counter stay in the top level.

Test Plan:
- Single-frame handshake: load addresses 0..63 with re = k, im = -k; start with num_frames=1, gap_cycles=0 -> src_valid high for 64 cycles starting in the 3rd cycle after start; sample k = (k, -k); done pulses once; busy falls.
- Multi-frame with gaps: num_frames=3, gap_cycles=5 -> three 64-cycle valid bursts separated by exactly 5 idle cycles; frames read from bases 0, 64, 128.
- Continuous mode with stop: continuous=1, stop pulsed mid-frame 2 -> frame 2 completes all 64 samples, no frame 3, then done.
- Base wrap-around: DEPTH=128, N=64, num_frames=3 -> frame 2 replays addresses 0..63.
- Sink counter: drive fft_valid for 130 cycles -> bin_index 0..63, 0..63, 0,1; out_frame = 2. With FFT_SRC_BITREV_EN, the second bin_index value is 32.
- Reset mid-burst: assert rst during PLAY -> all outputs 0 immediately, state IDLE, no done pulse; a following start replays from frame 0.
